// File: rtl/vme_request_decoder.sv
// Decodes a CPU bus cycle into one of three VME address-space requests and
// supervises the cycle until acknowledge, bus error, timeout or strobe release.
module vme_request_decoder #(
    parameter logic [15:0] A16_BASE       = 16'hFFFF,
    parameter logic [7:0]  A24_BASE       = 8'hFE,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_as,
    input  logic [31:0] cpu_address,
    input  logic [2:0]  cpu_fc,
    input  logic        vme_dtack,
    input  logic        vme_berr,
    output logic        request_vme_a16,
    output logic        request_vme_a24,
    output logic        request_vme_a40,
    output logic        cpu_berr
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        ACTIVE   = 3'd2,
        DONE     = 3'd3,
        WAIT_END = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  fc_q;
    logic [15:0] timer;

    logic cpu_space;
    logic hit_a16;
    logic hit_a24;
    logic hit_a40;
    logic unused_low_address;

    // CPU-space accesses never reach the VME bus; windows are checked A16 first.
    assign cpu_space = (fc_q == 3'b111);
    assign hit_a16   = !cpu_space && (addr_q[31:16] == A16_BASE);
    assign hit_a24   = !cpu_space && !hit_a16 && (addr_q[31:24] == A24_BASE);
    assign hit_a40   = !cpu_space && !hit_a16 && !hit_a24 && (addr_q[31:30] == 2'b10);

    assign unused_low_address = ^addr_q[15:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            request_vme_a16 <= 1'b1;
            request_vme_a24 <= 1'b1;
            request_vme_a40 <= 1'b1;
            cpu_berr        <= 1'b1;
            timer           <= 16'd0;
            addr_q          <= 32'd0;
            fc_q            <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    request_vme_a16 <= 1'b1;
                    request_vme_a24 <= 1'b1;
                    request_vme_a40 <= 1'b1;
                    cpu_berr        <= 1'b1;
                    if (!cpu_as) begin
                        addr_q <= cpu_address;
                        fc_q   <= cpu_fc;
                        state  <= DECODE;
                    end
                end

                DECODE: begin
                    request_vme_a16 <= !hit_a16;
                    request_vme_a24 <= !hit_a24;
                    request_vme_a40 <= !hit_a40;
                    cpu_berr        <= 1'b1;
                    timer           <= 16'd0;
                    if (hit_a16 || hit_a24 || hit_a40) begin
                        state <= ACTIVE;
                    end else begin
                        state <= WAIT_END;
                    end
                end

                // Strobe release beats bus error, which beats acknowledge, which beats timeout.
                ACTIVE: begin
                    if (timer != 16'hFFFF) begin
                        timer <= timer + 16'd1;
                    end
                    if (cpu_as) begin
                        request_vme_a16 <= 1'b1;
                        request_vme_a24 <= 1'b1;
                        request_vme_a40 <= 1'b1;
                        state           <= IDLE;
                    end else if (!vme_berr) begin
                        request_vme_a16 <= 1'b1;
                        request_vme_a24 <= 1'b1;
                        request_vme_a40 <= 1'b1;
                        cpu_berr        <= 1'b0;
                        state           <= WAIT_END;
                    end else if (!vme_dtack) begin
                        state <= DONE;
                    end else if (timer == TIMEOUT_LAST) begin
                        request_vme_a16 <= 1'b1;
                        request_vme_a24 <= 1'b1;
                        request_vme_a40 <= 1'b1;
                        cpu_berr        <= 1'b0;
                        state           <= WAIT_END;
                    end
                end

                DONE: begin
                    if (cpu_as) begin
                        request_vme_a16 <= 1'b1;
                        request_vme_a24 <= 1'b1;
                        request_vme_a40 <= 1'b1;
                        state           <= IDLE;
                    end
                end

                WAIT_END: begin
                    request_vme_a16 <= 1'b1;
                    request_vme_a24 <= 1'b1;
                    request_vme_a40 <= 1'b1;
                    if (cpu_as) begin
                        cpu_berr <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    request_vme_a16 <= 1'b1;
                    request_vme_a24 <= 1'b1;
                    request_vme_a40 <= 1'b1;
                    cpu_berr        <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vme_request_decoder.sv
// Scoreboard bench: stimulus queues each expected output change with the edge
// at which it must appear; a monitor pops and compares whenever the outputs move.
module tb_vme_request_decoder;

    localparam int TIMEOUT = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_as = 1'b1;
    logic [31:0] cpu_address = 32'd0;
    logic [2:0]  cpu_fc = 3'd0;
    logic        vme_dtack = 1'b1;
    logic        vme_berr = 1'b1;
    logic        request_vme_a16;
    logic        request_vme_a24;
    logic        request_vme_a40;
    logic        cpu_berr;
    logic [3:0]  out_vec;

    int          edge_no = 0;
    int          errors = 0;
    int          checks = 0;
    int          r;
    int          q_edge[$];
    logic [3:0]  q_vec[$];
    string       q_name[$];
    logic [3:0]  prev_vec = 4'b1111;

    vme_request_decoder #(
        .A16_BASE       (16'hFFFF),
        .A24_BASE       (8'hFE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_as          (cpu_as),
        .cpu_address     (cpu_address),
        .cpu_fc          (cpu_fc),
        .vme_dtack       (vme_dtack),
        .vme_berr        (vme_berr),
        .request_vme_a16 (request_vme_a16),
        .request_vme_a24 (request_vme_a24),
        .request_vme_a40 (request_vme_a40),
        .cpu_berr        (cpu_berr)
    );

    assign out_vec = {request_vme_a16, request_vme_a24, request_vme_a40, cpu_berr};

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            edge_no++;
        end
    end

    task automatic check_output(input string name, input logic [3:0] actual, input logic [3:0] required,
                                input int actual_edge, input int required_edge);
        checks++;
        if (actual !== required || actual_edge != required_edge) begin
            errors++;
            $display("[TB] FAIL %s: outputs {a16,a24,a40,berr}=%b at edge %0d, required %b at edge %0d",
                     name, actual, actual_edge, required, required_edge);
        end
    endtask

    task automatic expect_change(input string name, input int at_edge, input logic [3:0] vec);
        q_name.push_back(name);
        q_edge.push_back(at_edge);
        q_vec.push_back(vec);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic as_n, input logic [31:0] addr, input logic [2:0] fc);
        cpu_as      = as_n;
        cpu_address = addr;
        cpu_fc      = fc;
    endtask

    // Monitor: every output movement must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            checks++;
            if ($countones(~out_vec[3:1]) > 1) begin
                errors++;
                $display("[TB] FAIL one_request: requests=%b at edge %0d, required at most one low",
                         out_vec[3:1], edge_no);
            end
            if (out_vec !== prev_vec) begin
                if (q_vec.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_change: outputs=%b at edge %0d, required %b (no change expected)",
                             out_vec, edge_no, prev_vec);
                end else begin
                    check_output(q_name.pop_front(), out_vec, q_vec.pop_front(), edge_no, q_edge.pop_front());
                end
                prev_vec = out_vec;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        #6;
        check_output("reset_state", out_vec, 4'b1111, edge_no, 1);
        tick(2);
        reset = 1'b1;
        tick(2);

        // A16 cycle acknowledged three clocks after the request
        apply_stimulus(1'b0, 32'hFFFF1234, 3'd5);
        r = edge_no + 2;
        expect_change("a16_request", r, 4'b0111);
        tick(4);
        vme_dtack = 1'b0;
        tick(2);
        cpu_as    = 1'b1;
        vme_dtack = 1'b1;
        expect_change("a16_release", edge_no + 1, 4'b1111);
        tick(2);

        // A24 cycle with no acknowledge runs into the timeout
        apply_stimulus(1'b0, 32'hFE001000, 3'd1);
        r = edge_no + 2;
        expect_change("a24_request", r, 4'b1011);
        expect_change("a24_timeout", r + TIMEOUT, 4'b1110);
        tick(2 + TIMEOUT);
        cpu_as = 1'b1;
        expect_change("timeout_release", edge_no + 1, 4'b1111);
        tick(2);

        // A40: strobe release wins over a simultaneous VME bus error
        apply_stimulus(1'b0, 32'h80000000, 3'd6);
        r = edge_no + 2;
        expect_change("a40_request", r, 4'b1101);
        tick(2);
        vme_berr = 1'b0;
        cpu_as   = 1'b1;
        expect_change("a40_as_wins", r + 1, 4'b1111);
        tick(1);
        vme_berr = 1'b1;
        tick(1);

        // A40: bus error with strobe still low is passed to the CPU
        apply_stimulus(1'b0, 32'h80000000, 3'd6);
        r = edge_no + 2;
        expect_change("a40_request_2", r, 4'b1101);
        tick(2);
        vme_berr = 1'b0;
        expect_change("vme_berr_pass", r + 1, 4'b1110);
        tick(1);
        vme_berr = 1'b1;
        cpu_as   = 1'b1;
        expect_change("berr_release", r + 2, 4'b1111);
        tick(2);

        // Unmapped address and CPU space produce no outputs at all
        apply_stimulus(1'b0, 32'h00001000, 3'd2);
        tick(4);
        cpu_as = 1'b1;
        tick(1);
        apply_stimulus(1'b0, 32'hFFFF0000, 3'd7);
        tick(4);
        cpu_as = 1'b1;
        tick(1);

        // Next cycle starts right after the single idle clock
        apply_stimulus(1'b0, 32'hFFFF0000, 3'd2);
        expect_change("a16_after_idle", edge_no + 2, 4'b0111);
        tick(3);
        vme_dtack = 1'b0;
        tick(1);
        cpu_as    = 1'b1;
        vme_dtack = 1'b1;
        expect_change("a16_idle_release", edge_no + 1, 4'b1111);
        tick(2);

        // Acknowledge on the timeout edge wins: no bus error
        apply_stimulus(1'b0, 32'hFE00ABCD, 3'd1);
        r = edge_no + 2;
        expect_change("a24_request_2", r, 4'b1011);
        tick(2 + TIMEOUT - 1);
        vme_dtack = 1'b0;
        tick(2);
        cpu_as    = 1'b1;
        vme_dtack = 1'b1;
        expect_change("dtack_at_timeout_release", edge_no + 1, 4'b1111);
        tick(2);

        // Reset mid-ACTIVE clears outputs without a clock
        apply_stimulus(1'b0, 32'hFFFF5678, 3'd5);
        r = edge_no + 2;
        expect_change("a16_request_reset", r, 4'b0111);
        tick(3);
        #1;
        reset = 1'b0;
        expect_change("reset_abort", r + 1, 4'b1111);
        #1;
        check_output("async_reset", out_vec, 4'b1111, edge_no, r + 1);
        cpu_address = 32'hFE000000;
        cpu_fc      = 3'd1;
        tick(1);
        reset = 1'b1;
        expect_change("a24_after_reset", edge_no + 2, 4'b1011);
        tick(4);
        cpu_as = 1'b1;
        expect_change("final_release", edge_no + 1, 4'b1111);
        tick(3);

        checks++;
        if (q_vec.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_expectations: %0d changes never seen, required 0", q_vec.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
